// File: rtl/dff_share_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// Helpers work on an 8-requester superset; callers zero-extend and slice.
package dff_share_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam int MAX_REQ = 8;

  // First set request bit searching upward, circularly, starting just after last.
  // Scanning k from high to low lets the nearest candidate overwrite farther ones.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last,
                                         input int n);
    logic [2:0] win;
    int idx;
    win = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        if (req[3'(idx)]) win = 3'(idx);
      end
    end
    return win;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/dff_reg.sv
// WIDTH-bit D flip-flop bank with load enable and complementary output.
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (en)  q <= d;
  end

  assign qn = ~q;

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that serialises requester writes into one shared register.
// Optional owner/owner_vld outputs are built when DFF_SHARE_OWNER_EN is defined.
module dff_share_arbiter
  import dff_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qn,
  output logic                     busy
`ifdef DFF_SHARE_OWNER_EN
  ,
  output logic [IDW-1:0]           owner,
  output logic                     owner_vld
`endif
);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, ack_nxt;
  logic [IDW-1:0]     last, last_nxt, win_idx, win_nxt, pick;
  logic [7:0]         req_ext, oh_pick, oh_win;
  logic [2:0]         last_ext, win_ext, pick_ext;
  logic [WIDTH-1:0]   d_sel;
  logic               commit;
  logic               unused_bits;

  // Widen to the package's 8-requester superset.
  always_comb begin
    req_ext  = '0;
    last_ext = '0;
    win_ext  = '0;
    req_ext[NUM_REQ-1:0] = req;
    last_ext[IDW-1:0]    = last;
    win_ext[IDW-1:0]     = win_idx;
    pick_ext = rr_pick(req_ext, last_ext, NUM_REQ);
    pick     = pick_ext[IDW-1:0];
    oh_pick  = onehot(pick_ext);
    oh_win   = onehot(win_ext);
  end

  assign unused_bits = ^{pick_ext, oh_pick, oh_win};

  always_comb begin
    d_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDW'(i)) d_sel = wdata[i*WIDTH +: WIDTH];
    end
  end

  // A write only commits if the winner is still requesting at the GRANT edge.
  assign commit = (state == GRANT) && req[win_idx];
  assign busy   = (state == GRANT);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = '0;
    ack_nxt   = '0;
    last_nxt  = last;
    win_nxt   = win_idx;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          gnt_nxt   = oh_pick[NUM_REQ-1:0];
          win_nxt   = pick;
          last_nxt  = pick;
        end
      end
      GRANT: begin
        state_nxt = IDLE;
        if (commit) ack_nxt = oh_win[NUM_REQ-1:0];
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      gnt     <= '0;
      ack     <= '0;
      last    <= IDW'(NUM_REQ - 1);
      win_idx <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      ack     <= ack_nxt;
      last    <= last_nxt;
      win_idx <= win_nxt;
    end
  end

  dff_reg #(.WIDTH(WIDTH)) u_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (commit),
    .d       (d_sel),
    .q       (q),
    .qn      (qn)
  );

`ifdef DFF_SHARE_OWNER_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= '0;
      owner_vld <= 1'b0;
    end else if (commit) begin
      owner     <= win_idx;
      owner_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: directed vectors plus a per-cycle reference model.
module tb_dff_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt, ack;
  logic [W-1:0]   q, qn;
  logic           busy;
`ifdef DFF_SHARE_OWNER_EN
  logic [1:0]     owner;
  logic           owner_vld;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit           m_busy;
  int           m_last, m_win, m_owner;
  bit           m_ownv;
  logic [N-1:0] m_gnt, m_ack;
  logic [W-1:0] m_q;

  logic [3:0] gnt_tab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] q_tab   [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

  always #5 clock = ~clock;

  dff_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .wdata     (wdata),
    .gnt       (gnt),
    .ack       (ack),
    .q         (q),
    .qn        (qn),
    .busy      (busy)
`ifdef DFF_SHARE_OWNER_EN
    ,
    .owner     (owner),
    .owner_vld (owner_vld)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lane(input int i, input logic [7:0] v);
    wdata[i*W +: W] = v;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_last = N - 1; m_win = 0;
    m_gnt = '0; m_ack = '0; m_q = '0;
    m_owner = 0; m_ownv = 1'b0;
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  // One clock edge of the arbiter: either pick a winner or try to finish its write.
  task automatic model_edge();
    int w;
    if (!m_busy) begin
      m_ack = '0;
      m_gnt = '0;
      w = rr_winner(req, m_last);
      if (w >= 0) begin
        m_gnt = 4'(1 << w); m_win = w; m_last = w; m_busy = 1'b1;
      end
    end else begin
      m_gnt  = '0;
      m_busy = 1'b0;
      if (req[2'(m_win)]) begin
        m_q = wdata[m_win*W +: W]; m_ack = 4'(1 << m_win);
        m_owner = m_win; m_ownv = 1'b1;
      end else begin
        m_ack = '0;
      end
    end
  endtask

  task automatic compare_all();
    logic [W-1:0] m_qn;
    m_qn = ~m_q;
    check("mdl_gnt",  32'(gnt),  32'(m_gnt));
    check("mdl_ack",  32'(ack),  32'(m_ack));
    check("mdl_q",    32'(q),    32'(m_q));
    check("mdl_qn",   32'(qn),   32'(m_qn));
    check("mdl_busy", 32'(busy), 32'(m_busy));
`ifdef DFF_SHARE_OWNER_EN
    check("mdl_owner",     32'(owner),     32'(m_owner));
    check("mdl_owner_vld", 32'(owner_vld), 32'(m_ownv));
`endif
  endtask

  task automatic step();
    @(posedge clock);
    if (reset_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_q"},    32'(q),    32'h00);
    check({tag, "_qn"},   32'(qn),   32'hFF);
    check({tag, "_gnt"},  32'(gnt),  32'h0);
    check({tag, "_ack"},  32'(ack),  32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; req = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("rst");
    reset_n = 1'b1;

    // All requesters held high: grants rotate from requester 0
    for (int i = 0; i < N; i++) set_lane(i, 8'(8'h10 + i));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_gnt", 32'(gnt), 32'(gnt_tab[i]));
      step();
      check("rr_q", 32'(q), 32'(q_tab[i]));
    end
    req = '0;
    step();

    // Single requester 2
    set_lane(0, 8'h77); set_lane(1, 8'h11); set_lane(2, 8'hA5); set_lane(3, 8'h33);
    req = 4'b0100;
    step();
    check("single_gnt",  32'(gnt),  32'h4);
    check("single_busy", 32'(busy), 32'h1);
    set_lane(1, 8'hEE);
    step();
    check("single_q",   32'(q),   32'hA5);
    check("single_qn",  32'(qn),  32'h5A);
    check("single_ack", 32'(ack), 32'h4);
    req = '0;
    step();
    check("single_ack_clr", 32'(ack), 32'h0);

    // Abort: requester 0 drops during GRANT, then 0/1 both request
    req = 4'b0001;
    step();
    check("abort_gnt", 32'(gnt), 32'h1);
    req = '0;
    step();
    check("abort_ack", 32'(ack), 32'h0);
    check("abort_q",   32'(q),   32'hA5);
    set_lane(1, 8'h3C);
    req = 4'b0011;
    step();
    check("post_abort_gnt", 32'(gnt), 32'h2);
    step();
    check("post_abort_q",   32'(q),   32'h3C);
    check("post_abort_ack", 32'(ack), 32'h2);
    req = '0;
    step();

    // Reset asserted mid-GRANT takes effect without a clock edge
    req = 4'b0001;
    step();
    check("midrst_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    req = '0;
    step();
    reset_n = 1'b1;
    set_lane(3, 8'hC3);
    req = 4'b1000;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h8);
    step();
    check("post_rst_q",   32'(q),   32'hC3);
    check("post_rst_ack", 32'(ack), 32'h8);
`ifdef DFF_SHARE_OWNER_EN
    check("owner_val", 32'(owner),     32'h3);
    check("owner_vld", 32'(owner_vld), 32'h1);
`endif
    req = '0;
    step();

    // Another abort must leave the register (and owner) untouched
    req = 4'b0001;
    step();
    req = '0;
    step();
    check("abort2_q", 32'(q), 32'hC3);
`ifdef DFF_SHARE_OWNER_EN
    check("owner_keep", 32'(owner), 32'h3);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit D-flip-flop register.
- NUM_REQ requesters each present write data. The block grants one requester at a time and loads that requester's data into the register on the cycle after the grant.
- Drives q/qn outputs for downstream logic. Sits between requester blocks and the shared flip-flop bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register data width
- IDW, $clog2(NUM_REQ), requester index width (derived, not overridden)

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester write request, level-held until ack
- wdata  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- gnt  output  NUM_REQ  one-hot grant, high for exactly one cycle
- ack  output  NUM_REQ  one-hot write-done pulse, one cycle
- q  output  WIDTH  shared register value
- qn  output  WIDTH  bitwise complement of q, always
- busy  output  1  high while state is GRANT

Behaviour:
- Single clock; reset is asynchronous and active-low. reset_n low forces, immediately and without waiting for a clock edge:
  - state=IDLE, gnt=0, ack=0, q=0, qn=all ones, busy=0
  - round-robin pointer last=NUM_REQ-1, so requester 0 has first priority
- States: IDLE, GRANT.
- IDLE:
  - ack is cleared at every edge.
  - If req==0, remain in IDLE.
  - Otherwise, winner = first set req bit searching upward, circularly, from last+1.
  - Next edge: gnt<=onehot(winner), win_idx<=winner, last<=winner, state<=GRANT.
- GRANT (busy=1):
  - Next edge: gnt<=0 and state<=IDLE.
  - If req[win_idx] is still high: q<=wdata[win_idx] (data sampled at this edge) and ack<=onehot(win_idx).
  - If req[win_idx] has dropped: abort. No write, ack stays 0, pointer keeps its new value.
- Latency:
  - req rises at edge 0 (sampled in IDLE): gnt high after edge 1; q updated and ack high after edge 2.
  - Steady-state throughput is one write per 2 cycles.
- Fairness: with all req held high, grants cycle 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- Requester handshake: drop req in the cycle ack is seen. If req is still high in the IDLE cycle following ack, it is treated as a new request.
- req changes during GRANT for non-winners are ignored until the next IDLE.
- wdata of non-granted requesters never affects q.
- Reset mid-GRANT: write is abandoned, q=0.

Optional Feature:
- Macro: DFF_SHARE_OWNER_EN.
- Defined:
  - Adds output owner [IDW] and output owner_vld [1].
  - On every committed write, owner<=win_idx and owner_vld<=1.
  - Reset value: owner=0, owner_vld=0. Aborted writes leave both unchanged.
- Undefined: neither port exists, and no related flops are built.

Decomposition:
- Package dff_share_pkg:
  - state enum {IDLE, GRANT}
  - function rr_pick(req, last) returning the winner index
  - function onehot(idx)
- Sub-module dff_reg (WIDTH-bit D flip-flop bank):
  - ports clock, reset_n, en, d, q, qn
  - q<=d when en; qn=~q
  - The arbiter instantiates one dff_reg, with en = commit.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> q=8'h00, qn=8'hFF, gnt=0, ack=0, busy=0 immediately, before any clock edge.
- Single requester: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 after 1 edge; q=8'hA5, qn=8'h5A, ack=4'b0100 after 2 edges.
- Round-robin: req=4'b1111 held, wdata[i]=8'h10+i -> q sequence 8'h10, 11, 12, 13, 10 on every second edge; gnt sequence 0001, 0010, 0100, 1000, 0001.
- Abort: req=4'b0001 and req[0] dropped during GRANT -> no ack, q unchanged. With req=4'b0011 on the next IDLE -> grant goes to requester 1.
- Reset mid-op: q=8'h3C, then reset_n=0 during GRANT -> q=0, state IDLE. After release, req=4'b1000 -> requester 3 granted.
- Owner (with DFF_SHARE_OWNER_EN): write from requester 3 -> owner=2'd3, owner_vld=1; a subsequent abort leaves owner=2'd3.
